fig_ctrl: RTL and testbench
===========================

FIG_CTRL -- requirements
Module: fig_ctrl

Interface
REQ-001 SHALL have parameter POSE_FRAMES, default 8: frames a requested pose is held (1..64).
REQ-002 SHALL have parameter JUMP_FRAMES, default 16: frames the airborne position is held (1..64).
REQ-003 SHALL have port pixel_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port frame_start  in  1  one-cycle pulse at start of vertical blank.
REQ-006 SHALL have port pose_req  in  1  one-cycle pulse requesting a pose.
REQ-007 SHALL have port pose_id  in  2  pose index; sampled only when pose_req=1.
REQ-008 SHALL have port jump_req  in  1  one-cycle pulse requesting a jump.
REQ-009 SHALL have port DrawX, DrawY  in  10 each  current raster coordinate.
REQ-010 SHALL have port fig_select  out  2  sprite index to the figure layer.
REQ-011 SHALL have port pos_select  out  1  0 = ground anchor (FIG_Y_START_H), 1 = air anchor (FIG_Y_START_F).
REQ-012 SHALL have port fig_en  out  1  figure-window flag, aligned to the layer's color output.
REQ-013 SHALL have port busy  out  1  1 when state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, POSE, JUMP with a 6-bit frame counter cnt.
REQ-015 SHALL change fig_select, pos_select and state only in a cycle where frame_start=1; no mid-frame change.
REQ-016 SHALL latch pose_req into pose_pend and pose_id into pose_lat; a later pose_req before service overwrites pose_lat (last wins).
REQ-017 SHALL latch jump_req into jump_pend.
REQ-018 SHALL NOT service a request arriving in the same cycle as frame_start at that frame_start; it stays pending for the next one.
REQ-019 IDLE outputs: fig_select=0, pos_select=0.
REQ-020 At frame_start in IDLE or POSE: jump_pend -> JUMP, fig_select=3, pos_select=1, cnt=JUMP_FRAMES-1, both pending flags cleared.
REQ-021 Otherwise at frame_start in IDLE or POSE: pose_pend -> POSE, fig_select=pose_lat, pos_select=0, cnt=POSE_FRAMES-1, pose_pend cleared.
REQ-022 At frame_start in POSE with nothing pending: cnt=0 -> IDLE; else cnt decrements.
REQ-023 At frame_start in JUMP: cnt=0 -> IDLE; else cnt decrements. Requests pending at exit are serviced at the next frame_start.
REQ-024 While in JUMP, pose_req and jump_req are dropped: pending flags stay 0.
REQ-025 Jump takes priority over pose when both are pending.
REQ-026 The window hit SHALL be true when all hold:
- FIG_X_START <= DrawX < FIG_X_START+FIG_X_SIZE
- anchor <= DrawY < anchor+FIG_Y_SIZE
- anchor is chosen by the current pos_select
- comparisons use 11-bit unsigned arithmetic, so no wrap
REQ-027 fig_en SHALL equal the window hit delayed exactly 2 pixel_clk cycles (ROM read register plus color register).
REQ-028 busy SHALL be combinational from state.

Reset
REQ-029 With reset_n=0 at a clock edge, the next state SHALL be:
- state=IDLE, cnt=0
- pose_pend=0, jump_pend=0, pose_lat=0
- fig_select=0, pos_select=0, busy=0
- fig_en=0, both delay stages cleared
REQ-030 Reset SHALL override frame_start and requests in the same cycle, including mid-JUMP or mid-POSE.

Structure
REQ-031 Shared utils package SHALL hold FIG_X_START, FIG_X_SIZE, FIG_Y_SIZE, FIG_Y_START_H, FIG_Y_START_F and the fig_state_t enum (IDLE, POSE, JUMP).
REQ-032 Window compare plus 2-stage delay SHALL be one sub-module, fig_window; the FSM stays in fig_ctrl.

Verification
REQ-033 Pose hold: pose_req with pose_id=2 between frames -> next frame_start: fig_select=2, busy=1; after 8 further frame_starts: fig_select=0, busy=0.
REQ-034 Jump priority: pose_req(id=1) and jump_req in the same frame -> next frame_start: fig_select=3, pos_select=1; 16 frame_starts later IDLE; pose never shown.
REQ-035 Drop and same-cycle rule:
- pose_req during JUMP -> dropped, IDLE after jump.
- pose_req coincident with frame_start in IDLE -> applied one frame later, not at that frame_start.
REQ-036 Window alignment: pos_select=0, sweep DrawX across FIG_X_START-1..FIG_X_START+FIG_X_SIZE on row FIG_Y_START_H -> fig_en rises 2 cycles after DrawX=FIG_X_START and falls 2 cycles after DrawX=FIG_X_START+FIG_X_SIZE.
REQ-037 Reset mid-JUMP at cnt=7 -> next cycle: state=IDLE, pos_select=0, fig_select=0, fig_en=0; a jump_req pending before reset is lost.

Source files
------------

// File: rtl/fig_ctrl_pkg.sv
// Shared figure-layer geometry and controller state type.
package fig_ctrl_pkg;

    localparam logic [9:0] FIG_X_START   = 10'd100;
    localparam logic [9:0] FIG_X_SIZE    = 10'd64;
    localparam logic [9:0] FIG_Y_SIZE    = 10'd96;
    localparam logic [9:0] FIG_Y_START_H = 10'd300;
    localparam logic [9:0] FIG_Y_START_F = 10'd200;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POSE = 2'd1,
        JUMP = 2'd2
    } fig_state_t;

endpackage

// File: rtl/fig_window.sv
// Figure window hit test, delayed two cycles to line up with the layer's color output.
module fig_window
    import fig_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] draw_x,
    input  logic [9:0] draw_y,
    input  logic       pos_select,
    output logic       fig_en
);

    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] anchor;
    logic        hit;
    logic        hit_d;

    // Widened by one bit so start+size never wraps.
    always_comb begin
        x      = {1'b0, draw_x};
        y      = {1'b0, draw_y};
        anchor = pos_select ? {1'b0, FIG_Y_START_F} : {1'b0, FIG_Y_START_H};
        hit    = (x >= {1'b0, FIG_X_START}) &&
                 (x <  ({1'b0, FIG_X_START} + {1'b0, FIG_X_SIZE})) &&
                 (y >= anchor) &&
                 (y <  (anchor + {1'b0, FIG_Y_SIZE}));
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hit_d  <= 1'b0;
            fig_en <= 1'b0;
        end else begin
            hit_d  <= hit;
            fig_en <= hit_d;
        end
    end

endmodule

// File: rtl/fig_ctrl.sv
// Figure pose/jump controller: frame-synchronous sprite and anchor selection.
module fig_ctrl
    import fig_ctrl_pkg::*;
#(
    parameter int unsigned POSE_FRAMES = 8,
    parameter int unsigned JUMP_FRAMES = 16
) (
    input  logic       pixel_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       pose_req,
    input  logic [1:0] pose_id,
    input  logic       jump_req,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [1:0] fig_select,
    output logic       pos_select,
    output logic       fig_en,
    output logic       busy
);

    localparam logic [5:0] POSE_LOAD = 6'(POSE_FRAMES - 1);
    localparam logic [5:0] JUMP_LOAD = 6'(JUMP_FRAMES - 1);

    fig_state_t state, state_n;
    logic [5:0] cnt, cnt_n;
    logic       pose_pend, pose_pend_n;
    logic       jump_pend, jump_pend_n;
    logic [1:0] pose_lat, pose_lat_n;
    logic [1:0] fig_n;
    logic       pos_n;

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pose_pend  <= 1'b0;
            jump_pend  <= 1'b0;
            pose_lat   <= '0;
            fig_select <= '0;
            pos_select <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pose_pend  <= pose_pend_n;
            jump_pend  <= jump_pend_n;
            pose_lat   <= pose_lat_n;
            fig_select <= fig_n;
            pos_select <= pos_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        fig_n       = fig_select;
        pos_n       = pos_select;
        pose_pend_n = pose_pend;
        jump_pend_n = jump_pend;
        pose_lat_n  = pose_lat;

        // Decisions use only the registered pending flags, so a request
        // arriving alongside frame_start waits for the following frame.
        if (frame_start) begin
            unique case (state)
                IDLE, POSE: begin
                    if (jump_pend) begin
                        state_n     = JUMP;
                        fig_n       = 2'd3;
                        pos_n       = 1'b1;
                        cnt_n       = JUMP_LOAD;
                        jump_pend_n = 1'b0;
                        pose_pend_n = 1'b0;
                    end else if (pose_pend) begin
                        state_n     = POSE;
                        fig_n       = pose_lat;
                        pos_n       = 1'b0;
                        cnt_n       = POSE_LOAD;
                        pose_pend_n = 1'b0;
                    end else if (state == POSE) begin
                        if (cnt == '0) begin
                            state_n = IDLE;
                            fig_n   = '0;
                            pos_n   = 1'b0;
                        end else begin
                            cnt_n = cnt - 6'd1;
                        end
                    end
                end
                JUMP: begin
                    if (cnt == '0) begin
                        state_n = IDLE;
                        fig_n   = '0;
                        pos_n   = 1'b0;
                    end else begin
                        cnt_n = cnt - 6'd1;
                    end
                end
                default: begin
                    state_n = IDLE;
                    fig_n   = '0;
                    pos_n   = 1'b0;
                    cnt_n   = '0;
                end
            endcase
        end

        // Requests are ignored while airborne, including the cycle a jump starts.
        if (state != JUMP && state_n != JUMP) begin
            if (pose_req) begin
                pose_pend_n = 1'b1;
                pose_lat_n  = pose_id;
            end
            if (jump_req) begin
                jump_pend_n = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    fig_window u_window (
        .clk        (pixel_clk),
        .reset_n    (reset_n),
        .draw_x     (DrawX),
        .draw_y     (DrawY),
        .pos_select (pos_select),
        .fig_en     (fig_en)
    );

endmodule

// File: tb/tb_fig_ctrl.sv
// Directed bench for fig_ctrl: vector table plus hand-written multi-frame sequences.
module tb_fig_ctrl;
    import fig_ctrl_pkg::*;

    logic       pixel_clk = 1'b0;
    logic       reset_n   = 1'b0;
    logic       frame_start = 1'b0;
    logic       pose_req  = 1'b0;
    logic [1:0] pose_id   = '0;
    logic       jump_req  = 1'b0;
    logic [9:0] DrawX     = '0;
    logic [9:0] DrawY     = '0;
    logic [1:0] fig_select;
    logic       pos_select;
    logic       fig_en;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 pixel_clk = ~pixel_clk;

    fig_ctrl #(.POSE_FRAMES(8), .JUMP_FRAMES(16)) dut (
        .pixel_clk   (pixel_clk),
        .reset_n     (reset_n),
        .frame_start (frame_start),
        .pose_req    (pose_req),
        .pose_id     (pose_id),
        .jump_req    (jump_req),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .fig_select  (fig_select),
        .pos_select  (pos_select),
        .fig_en      (fig_en),
        .busy        (busy)
    );

    typedef struct {
        logic       fs;
        logic       pr;
        logic [1:0] pid;
        logic       jr;
        logic [1:0] fig;
        logic       pos;
        logic       bsy;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] fig, input logic pos, input logic bsy);
        check({name, ".fig_select"}, 32'(fig_select), 32'(fig));
        check({name, ".pos_select"}, 32'(pos_select), 32'(pos));
        check({name, ".busy"}, 32'(busy), 32'(bsy));
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic step(input logic fs, input logic pr, input logic [1:0] pid, input logic jr);
        @(negedge pixel_clk);
        frame_start = fs;
        pose_req    = pr;
        pose_id     = pid;
        jump_req    = jr;
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge pixel_clk);
        reset_n = 1'b0;
        frame_start = 1'b0; pose_req = 1'b0; pose_id = '0; jump_req = 1'b0;
        @(posedge pixel_clk);
        #1;
        @(negedge pixel_clk);
        reset_n = 1'b1;
    endtask

    function automatic logic hit_model(input int x, input int y, input logic pos);
        int anchor;
        anchor = pos ? int'(FIG_Y_START_F) : int'(FIG_Y_START_H);
        return (x >= int'(FIG_X_START)) && (x < int'(FIG_X_START) + int'(FIG_X_SIZE)) &&
               (y >= anchor) && (y < anchor + int'(FIG_Y_SIZE));
    endfunction

    initial begin
        logic exp_prev;

        //            fs    pr    pid   jr    fig   pos   busy
        tbl[0] = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 2'd3, 1'b0, 2'd1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, 2'd2, 1'b0, 2'd3, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b1};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd3, 1'b1, 1'b1};
        tbl[9] = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd3, 1'b1, 1'b1};

        // Reset state
        @(posedge pixel_clk);
        #1;
        check_out("reset", 2'd0, 1'b0, 1'b0);
        check("reset.fig_en", 32'(fig_en), 32'd0);
        @(negedge pixel_clk);
        reset_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].fs, tbl[i].pr, tbl[i].pid, tbl[i].jr);
            check_out($sformatf("vec%0d", i), tbl[i].fig, tbl[i].pos, tbl[i].bsy);
        end

        // Pose hold for 8 frames
        do_reset();
        step(1'b0, 1'b1, 2'd2, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("pose_enter", 2'd2, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            step(1'b1, 1'b0, 2'd0, 1'b0);
            check_out($sformatf("pose_hold%0d", i), 2'd2, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("pose_exit", 2'd0, 1'b0, 1'b0);

        // Jump priority over pose in same frame
        step(1'b0, 1'b1, 2'd1, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("jump_enter", 2'd3, 1'b1, 1'b1);
        for (int i = 1; i <= 15; i++) begin
            step(1'b1, 1'b0, 2'd0, 1'b0);
            check_out($sformatf("jump_hold%0d", i), 2'd3, 1'b1, 1'b1);
        end
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("jump_exit", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("jump_no_pose", 2'd0, 1'b0, 1'b0);

        // Pose request during jump is dropped
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b1, 2'd2, 1'b0);
        check_out("drop_mid", 2'd3, 1'b1, 1'b1);
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("drop_exit", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("drop_after", 2'd0, 1'b0, 1'b0);

        // Request coincident with frame_start in IDLE waits one frame
        step(1'b1, 1'b1, 2'd1, 1'b0);
        check_out("same_cycle", 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("same_cycle_next", 2'd1, 1'b0, 1'b1);

        // Window alignment: horizontal sweep on the ground row
        do_reset();
        DrawY = FIG_Y_START_H;
        DrawX = FIG_X_START - 10'd1;
        exp_prev = 1'b0;
        for (int x = int'(FIG_X_START) - 1; x <= int'(FIG_X_START) + int'(FIG_X_SIZE) + 2; x++) begin
            @(negedge pixel_clk);
            DrawX = 10'(x);
            @(posedge pixel_clk);
            #1;
            check($sformatf("sweep_x%0d", x - 1), 32'(fig_en), 32'(exp_prev));
            exp_prev = hit_model(x, int'(FIG_Y_START_H), 1'b0);
        end
        // Vertical boundaries of the ground window
        DrawX = FIG_X_START + 10'd5;
        for (int y = int'(FIG_Y_START_H) - 2; y <= int'(FIG_Y_START_H) + int'(FIG_Y_SIZE) + 1; y += 1) begin
            if (y > int'(FIG_Y_START_H) + 2 && y < int'(FIG_Y_START_H) + int'(FIG_Y_SIZE) - 2) continue;
            @(negedge pixel_clk);
            DrawY = 10'(y);
            @(posedge pixel_clk);
            @(posedge pixel_clk);
            #1;
            check($sformatf("sweep_y%0d", y), 32'(fig_en),
                  32'(hit_model(int'(FIG_X_START) + 5, y, 1'b0)));
        end

        // Reset mid-jump at cnt=7 with coincident frame_start and pose_req
        do_reset();
        DrawX = FIG_X_START + 10'd20;
        DrawY = FIG_Y_START_F + 10'd50;
        step(1'b0, 1'b0, 2'd0, 1'b1);
        step(1'b1, 1'b0, 2'd0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b0, 1'b0, 2'd0, 1'b0);
        check("midjump.cnt", 32'(dut.cnt), 32'd7);
        check_out("midjump", 2'd3, 1'b1, 1'b1);
        check("midjump.fig_en", 32'(fig_en), 32'd1);
        @(negedge pixel_clk);
        reset_n = 1'b0; frame_start = 1'b1; pose_req = 1'b1; pose_id = 2'd2;
        @(posedge pixel_clk);
        #1;
        check_out("midjump_reset", 2'd0, 1'b0, 1'b0);
        check("midjump_reset.fig_en", 32'(fig_en), 32'd0);
        @(negedge pixel_clk);
        reset_n = 1'b1; frame_start = 1'b0; pose_req = 1'b0;
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("midjump_after", 2'd0, 1'b0, 1'b0);

        // Pending jump is lost across reset
        step(1'b0, 1'b0, 2'd0, 1'b1);
        do_reset();
        step(1'b1, 1'b0, 2'd0, 1'b0);
        check_out("pend_lost", 2'd0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
